// File: rtl/bullet_controller_if.sv
// Bullet controller bus: tank/fire/collision inputs and bullet state outputs.
interface bullet_controller_if;
  logic       frame_tick;
  logic       fire;
  logic [9:0] TankX;
  logic [9:0] TankY;
  logic [1:0] direction;
  logic       bullet_collision;
  logic       tank_hit;
  logic [9:0] BulletX;
  logic [9:0] BulletY;
  logic [9:0] Bullet_Size;
  logic       bullet_active;
  logic       hit_event;
  logic [7:0] shot_count;

  modport master (
    output frame_tick, fire, TankX, TankY, direction, bullet_collision, tank_hit,
    input  BulletX, BulletY, Bullet_Size, bullet_active, hit_event, shot_count
  );

  modport slave (
    input  frame_tick, fire, TankX, TankY, direction, bullet_collision, tank_hit,
    output BulletX, BulletY, Bullet_Size, bullet_active, hit_event, shot_count
  );
endinterface

// File: rtl/bullet_controller.sv
// Single-bullet controller: fire-edge capture, spawn at muzzle, per-frame
// motion, collision/out-of-bounds termination and post-shot cooldown.
module bullet_controller #(
  parameter int BULLET_SPEED    = 4,
  parameter int BULLET_SIZE     = 4,
  parameter int MUZZLE_OFFSET   = 12,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int X_MAX           = 639,
  parameter int Y_MAX           = 479
) (
  input  logic Clk,
  input  logic Reset,
  bullet_controller_if.slave bus
);
  localparam int CW = 16;
  localparam logic signed [10:0] OFF  = 11'(MUZZLE_OFFSET);
  localparam logic signed [10:0] SPD  = 11'(BULLET_SPEED);
  localparam logic signed [10:0] XM   = 11'(X_MAX);
  localparam logic signed [10:0] YM   = 11'(Y_MAX);
  localparam logic [CW-1:0]      LOAD = CW'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {IDLE, ACTIVE, COOLDOWN} state_t;

  state_t        r_state;
  logic          r_fire_prev;
  logic          r_fire_req;
  logic [1:0]    r_dir;
  logic [9:0]    r_x, r_y;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_shots;
  logic          r_hit;
  logic          r_active;

  logic               w_fire_edge;
  logic signed [10:0] w_spawn_x, w_spawn_y;
  logic signed [10:0] w_next_x, w_next_y;
  logic               w_spawn_inb, w_next_inb;

  // Move a point by amt along a heading, in 11-bit signed so that stepping
  // past the 0 edge shows up as a negative coordinate.
  function automatic logic [21:0] offset_pt(input logic [9:0] x, input logic [9:0] y,
                                            input logic [1:0] d, input logic signed [10:0] amt);
    logic signed [10:0] sx, sy;
    sx = $signed({1'b0, x});
    sy = $signed({1'b0, y});
    case (d)
      2'b00:   sy = sy - amt;
      2'b01:   sx = sx + amt;
      2'b10:   sy = sy + amt;
      default: sx = sx - amt;
    endcase
    return {sx, sy};
  endfunction

  function automatic logic in_bounds(input logic signed [10:0] sx, input logic signed [10:0] sy);
    return (sx >= 11'sd0) && (sx <= XM) && (sy >= 11'sd0) && (sy <= YM);
  endfunction

  // Candidate spawn point from the tank and next step from the bullet.
  always_comb begin
    w_fire_edge = bus.fire & ~r_fire_prev;
    {w_spawn_x, w_spawn_y} = offset_pt(bus.TankX, bus.TankY, bus.direction, OFF);
    {w_next_x, w_next_y}   = offset_pt(r_x, r_y, r_dir, SPD);
    w_spawn_inb = in_bounds(w_spawn_x, w_spawn_y);
    w_next_inb  = in_bounds(w_next_x, w_next_y);
  end

  assign bus.BulletX       = r_x;
  assign bus.BulletY       = r_y;
  assign bus.Bullet_Size   = 10'(BULLET_SIZE);
  assign bus.bullet_active = r_active;
  assign bus.hit_event     = r_hit;
  assign bus.shot_count    = r_shots;

  // Bullet FSM; everything except fire capture and hit pulse waits for frame_tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_fire_prev <= 1'b0;
      r_fire_req  <= 1'b0;
      r_dir       <= 2'b00;
      r_x         <= '0;
      r_y         <= '0;
      r_cnt       <= '0;
      r_shots     <= '0;
      r_hit       <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_fire_prev <= bus.fire;
      r_hit       <= 1'b0;
      if (bus.frame_tick) begin
        // A pending request is consumed or dropped at every tick, never queued.
        r_fire_req <= 1'b0;
        case (r_state)
          IDLE: begin
            if (r_fire_req) begin
              r_dir   <= bus.direction;
              r_shots <= r_shots + 8'd1;
              if (w_spawn_inb) begin
                r_state  <= ACTIVE;
                r_active <= 1'b1;
                r_x      <= w_spawn_x[9:0];
                r_y      <= w_spawn_y[9:0];
              end else begin
                r_state <= COOLDOWN;
                r_cnt   <= LOAD;
                r_x     <= '0;
                r_y     <= '0;
              end
            end
          end
          ACTIVE: begin
            if (bus.bullet_collision || bus.tank_hit) begin
              r_state  <= COOLDOWN;
              r_active <= 1'b0;
              r_cnt    <= LOAD;
              r_x      <= '0;
              r_y      <= '0;
              r_hit    <= 1'b1;
            end else if (w_next_inb) begin
              r_x <= w_next_x[9:0];
              r_y <= w_next_y[9:0];
            end else begin
              r_state  <= COOLDOWN;
              r_active <= 1'b0;
              r_cnt    <= LOAD;
              r_x      <= '0;
              r_y      <= '0;
            end
          end
          COOLDOWN: begin
            // A zero load also falls through here on the first tick.
            if (r_cnt <= CW'(1)) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end else if (w_fire_edge) begin
        r_fire_req <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bullet_controller.sv
// Bench for bullet_controller: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a frame-level model.
module tb_bullet_controller;
  localparam int COOL = 30;
  localparam int XMAX = 639;
  localparam int YMAX = 479;

  logic Clk = 1'b0;
  logic Reset;
  bullet_controller_if bus ();

  bullet_controller #(
    .BULLET_SPEED(4), .BULLET_SIZE(4), .MUZZLE_OFFSET(12),
    .COOLDOWN_FRAMES(COOL), .X_MAX(XMAX), .Y_MAX(YMAX)
  ) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 = waiting for a shot, 1 = bullet flying, 2 = resting.
  int m_mode, m_x, m_y, m_wait, m_shots, m_head;
  bit m_hit, m_req, m_prev;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void step_pt(input int d, input int amt, inout int x, inout int y);
    case (d)
      0: y -= amt;
      1: x += amt;
      2: y += amt;
      default: x -= amt;
    endcase
  endfunction

  function automatic bit inb(input int x, input int y);
    return x >= 0 && x <= XMAX && y >= 0 && y <= YMAX;
  endfunction

  function automatic void rest();
    m_mode = 2; m_x = 0; m_y = 0; m_wait = COOL;
  endfunction

  // Advance the model by one Clk using the inputs the DUT sees at this edge.
  function automatic void model_step();
    int nx, ny;
    if (Reset) begin
      m_mode = 0; m_x = 0; m_y = 0; m_wait = 0; m_shots = 0;
      m_hit = 0; m_req = 0; m_prev = 0;
      return;
    end
    m_hit = 0;
    if (bus.frame_tick) begin
      if (m_mode == 0 && m_req) begin
        m_head = int'(bus.direction);
        nx = int'(bus.TankX); ny = int'(bus.TankY);
        step_pt(m_head, 12, nx, ny);
        m_shots = (m_shots + 1) % 256;
        if (inb(nx, ny)) begin m_mode = 1; m_x = nx; m_y = ny; end
        else rest();
      end else if (m_mode == 1) begin
        if (bus.bullet_collision || bus.tank_hit) begin
          rest(); m_hit = 1;
        end else begin
          nx = m_x; ny = m_y;
          step_pt(m_head, 4, nx, ny);
          if (inb(nx, ny)) begin m_x = nx; m_y = ny; end
          else rest();
        end
      end else if (m_mode == 2) begin
        if (m_wait <= 1) begin m_mode = 0; m_wait = 0; end
        else m_wait--;
      end
      m_req = 0;
    end else if (bus.fire && !m_prev) begin
      m_req = 1;
    end
    m_prev = bus.fire;
  endfunction

  // One Clk: update model at the edge, compare DUT just after it.
  task automatic cyc();
    @(posedge Clk);
    model_step();
    #1;
    check("BulletX", int'(bus.BulletX), m_x);
    check("BulletY", int'(bus.BulletY), m_y);
    check("bullet_active", int'(bus.bullet_active), int'(m_mode == 1));
    check("hit_event", int'(bus.hit_event), int'(m_hit));
    check("shot_count", int'(bus.shot_count), m_shots);
    check("Bullet_Size", int'(bus.Bullet_Size), 4);
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1; cyc();
    bus.frame_tick = 1'b0; cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fire_edge();
    bus.fire = 1'b1; cyc();
    bus.fire = 1'b0; cyc();
  endtask

  task automatic do_reset();
    Reset = 1'b1; cyc(); cyc();
    Reset = 1'b0; cyc();
  endtask

  task automatic setup(input int tx, input int ty, input int d);
    bus.TankX = 10'(tx); bus.TankY = 10'(ty); bus.direction = 2'(d);
  endtask

  // Tick whose outputs are checked right after the tick edge.
  task automatic tick_hold();
    bus.frame_tick = 1'b1; cyc();
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    bus.frame_tick = 1'b0; bus.fire = 1'b0; bus.bullet_collision = 1'b0; bus.tank_hit = 1'b0;
    setup(320, 240, 1);
    do_reset();
    check("reset BulletX", int'(bus.BulletX), 0);
    check("reset active", int'(bus.bullet_active), 0);
    check("reset shots", int'(bus.shot_count), 0);
    check("reset hit", int'(bus.hit_event), 0);

    // Spawn to the right of (320,240), then three frames of motion.
    fire_edge();
    tick_hold();
    check("spawn X", int'(bus.BulletX), 332);
    check("spawn Y", int'(bus.BulletY), 240);
    check("spawn active", int'(bus.bullet_active), 1);
    check("spawn shots", int'(bus.shot_count), 1);
    cyc();
    ticks(3);
    check("move X", int'(bus.BulletX), 344);

    // Collision at (100,200), cooldown length and no queued shots.
    do_reset();
    setup(88, 200, 1);
    fire_edge(); tick();
    check("at 100", int'(bus.BulletX), 100);
    bus.bullet_collision = 1'b1; tick_hold();
    check("coll hit", int'(bus.hit_event), 1);
    check("coll X", int'(bus.BulletX), 0);
    check("coll active", int'(bus.bullet_active), 0);
    bus.bullet_collision = 1'b0; cyc();
    check("hit pulse ends", int'(bus.hit_event), 0);
    ticks(COOL - 1);
    fire_edge(); tick();
    check("cooldown fire dropped", int'(bus.bullet_active), 0);
    tick();
    check("not queued", int'(bus.bullet_active), 0);
    fire_edge(); tick();
    check("refire after cool", int'(bus.bullet_active), 1);
    // Heading is latched at spawn.
    bus.direction = 2'b00; tick();
    check("heading X", int'(bus.BulletX), 104);
    check("heading Y", int'(bus.BulletY), 200);

    // Leaving through the top edge: no hit, then cooldown eats a fire edge.
    do_reset();
    setup(50, 14, 0);
    fire_edge(); tick();
    check("top Y", int'(bus.BulletY), 2);
    tick_hold();
    check("oob active", int'(bus.bullet_active), 0);
    check("oob hit", int'(bus.hit_event), 0);
    cyc();
    fire_edge(); ticks(COOL); tick();
    check("oob no spawn", int'(bus.bullet_active), 0);

    // Spawn off the left edge goes straight to cooldown.
    do_reset();
    setup(5, 100, 3);
    fire_edge(); tick();
    check("offscreen active", int'(bus.bullet_active), 0);
    check("offscreen shots", int'(bus.shot_count), 1);
    check("offscreen X", int'(bus.BulletX), 0);

    // Collision wins over crossing X_MAX.
    do_reset();
    setup(625, 100, 1);
    fire_edge(); tick();
    check("edge X", int'(bus.BulletX), 637);
    bus.bullet_collision = 1'b1; tick_hold();
    check("priority hit", int'(bus.hit_event), 1);
    bus.bullet_collision = 1'b0; cyc();

    // Held fire over 10 frames is one shot.
    do_reset();
    setup(320, 240, 1);
    bus.fire = 1'b1; cyc();
    ticks(10);
    bus.fire = 1'b0; cyc();
    check("held fire shots", int'(bus.shot_count), 1);

    // Reset mid-flight aborts, pending request included.
    do_reset();
    setup(188, 200, 1);
    fire_edge(); tick();
    check("pre-reset X", int'(bus.BulletX), 200);
    bus.fire = 1'b1; cyc();
    bus.fire = 1'b0; Reset = 1'b1; cyc();
    check("abort X", int'(bus.BulletX), 0);
    check("abort active", int'(bus.bullet_active), 0);
    check("abort shots", int'(bus.shot_count), 0);
    Reset = 1'b0; cyc(); tick();
    check("post-reset no shot", int'(bus.bullet_active), 0);

    // 256 shots wrap the counter.
    setup(320, 240, 1);
    for (int i = 0; i < 256; i++) begin
      fire_edge(); tick();
      bus.bullet_collision = 1'b1; tick();
      bus.bullet_collision = 1'b0;
      ticks(COOL);
      if (i == 254) check("shots 255", int'(bus.shot_count), 255);
    end
    check("shots wrap", int'(bus.shot_count), 0);

    // Randomized traffic.
    for (int i = 0; i < 6000; i++) begin
      Reset = ($urandom_range(0, 399) == 0);
      bus.frame_tick = ($urandom_range(0, 2) == 0);
      if (!bus.frame_tick && $urandom_range(0, 3) == 0) bus.fire = ~bus.fire;
      if ($urandom_range(0, 7) == 0) bus.direction = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) begin
        bus.TankX = 10'($urandom_range(0, 700));
        bus.TankY = 10'($urandom_range(0, 520));
      end
      bus.bullet_collision = ($urandom_range(0, 9) == 0);
      bus.tank_hit = ($urandom_range(0, 15) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bullet_controller.md
BULLET_CONTROLLER -- requirements
Module: bullet_controller

Interface
REQ-001 Parameter BULLET_SPEED, default 4, pixels moved per frame_tick.
REQ-002 Parameter BULLET_SIZE, default 4, half-size driven on Bullet_Size.
REQ-003 Parameter MUZZLE_OFFSET, default 12, spawn distance from tank centre.
REQ-004 Parameter COOLDOWN_FRAMES, default 30, frames between despawn and next allowed shot.
REQ-005 Parameters X_MAX / Y_MAX, defaults 639 / 479, inclusive playfield limits; minimum is 0.
REQ-006 Clk  in  1  system clock.
REQ-007 Reset  in  1  synchronous, active-high.
REQ-008 frame_tick  in  1  one-Clk pulse per video frame.
REQ-009 fire  in  1  level fire button.
REQ-010 TankX, TankY  in  10 each  firing tank centre.
REQ-011 direction  in  2  00 up, 01 right, 10 down, 11 left.
REQ-012 bullet_collision  in  1  barrier collision flag for this bullet.
REQ-013 tank_hit  in  1  bullet overlaps opposing tank.
REQ-014 BulletX, BulletY  out  10 each  bullet centre; 0,0 when parked.
REQ-015 Bullet_Size  out  10  constant BULLET_SIZE.
REQ-016 bullet_active  out  1  high only in ACTIVE.
REQ-017 hit_event  out  1  one-Clk pulse on collision/hit termination.
REQ-018 shot_count  out  8  bullets spawned, wraps 255->0.

Function
REQ-019 FSM states IDLE, ACTIVE, COOLDOWN; state, position, counter change only on frame_tick, except fire_req and hit_event.
REQ-020 fire_req set on Clk when fire is 1 and was 0 the previous Clk; held until next frame_tick, then cleared regardless of state.
REQ-021 IDLE + frame_tick + fire_req: latch direction, compute spawn = tank centre offset by MUZZLE_OFFSET along direction (11-bit signed), increment shot_count.
REQ-022 Spawn in bounds (0..X_MAX, 0..Y_MAX) -> ACTIVE with BulletX/Y = spawn; out of bounds -> COOLDOWN, counter = COOLDOWN_FRAMES, position parked.
REQ-023 ACTIVE + frame_tick: if bullet_collision or tank_hit -> COOLDOWN, park, load counter, pulse hit_event.
REQ-024 ACTIVE + frame_tick, no collision: next = position +/- BULLET_SPEED along latched direction, computed 11-bit signed; in bounds -> update position; out of bounds -> COOLDOWN, park, load counter, no hit_event.
REQ-025 Collision takes priority over motion and out-of-bounds on the same tick.
REQ-026 bullet_collision and tank_hit ignored outside ACTIVE.
REQ-027 COOLDOWN + frame_tick: decrement counter; counter reaching 0 -> IDLE; COOLDOWN_FRAMES=0 returns to IDLE on first tick.
REQ-028 fire_req in ACTIVE or COOLDOWN discarded at the tick; never queued.
REQ-029 Direction changes during ACTIVE do not alter bullet heading.
REQ-030 Outputs registered; update one Clk after the frame_tick cycle.

Reset
REQ-031 Reset: state IDLE, BulletX/Y = 0, bullet_active = 0, hit_event = 0, fire_req = 0, counter = 0, shot_count = 0, fire-edge history = 0.
REQ-032 Reset mid-flight or in COOLDOWN aborts immediately; next shot needs a new fire edge after Reset deasserts.

Verification
REQ-033 Tank (320,240), dir 01, fire edge, tick -> BulletX=332, BulletY=240, active=1, shot_count=1; 3 more ticks -> BulletX=344.
REQ-034 Active at (100,200), bullet_collision=1 at tick -> hit_event pulse, BulletX/Y=0,0, COOLDOWN; 30 ticks later IDLE.
REQ-035 Dir 00, bullet at Y=2, tick -> out of bounds, COOLDOWN, no hit_event; fire edge during COOLDOWN -> no spawn after return to IDLE.
REQ-036 Tank (5,100), dir 11, fire -> spawn X=-7 out of bounds -> COOLDOWN directly, shot_count increments, active never high.
REQ-037 bullet_collision and crossing X_MAX on same tick -> hit_event=1 (collision priority); fire held level 10 frames -> one shot only.
REQ-038 Reset asserted in ACTIVE at (200,200) -> next Clk IDLE, 0,0, shot_count=0; 256 shots -> shot_count wraps to 0.
